nanov_word_uart_tx: RTL
=======================

// Module: nanov_word_uart_tx
// PURPOSE
//  Downstream consumer of the CPU output-word strobe (raw_data_out/latch_data_out), alongside the
//  LED data register. Buffers latched 32-bit words in a small FIFO and serialises each as 4 UART
//  bytes, MSB byte first, 8N1, so that program output can be logged on a host over a serial link.
//  Sits in the CPU clock domain; the CPU never stalls, and words arriving when the FIFO is full are dropped.
// PARAMETERS
//  CLKS_PER_BIT  347  cpu clock cycles per UART bit (40 MHz / 115200); legal range >= 2
//  FIFO_DEPTH    4    word entries; power of 2, >= 2
// PORTS
//  clk         in   1   CPU clock; all logic on rising edge
//  rstn        in   1   asynchronous active-low reset
//  data_in     in   32  word to send; sampled only when latch_in=1
//  latch_in    in   1   one-cycle push strobe (CPU latch_data_out)
//  uart_tx     out  1   serial output, idle high, registered
//  busy        out  1   1 while the FIFO is non-empty or a frame is in progress
//  overflow    out  1   sticky: set when a push is dropped; cleared only by reset
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO; excludes the word being shifted
// BEHAVIOUR
//  Reset (async, rstn=0): uart_tx=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, FIFO emptied.
//   Reset mid-frame aborts immediately: uart_tx returns to 1 and partial words are lost.
//  FIFO: circular buffer with wrapping rd/wr pointers and a separate count.
//   - push: latch_in=1 and (level<DEPTH or pop in same cycle) -> write data_in, advance wr pointer.
//   - push while full with no pop in that cycle -> data_in discarded, overflow<=1, level unchanged.
//   - push and pop in the same cycle -> level unchanged, both pointers advance.
//  FSM states: IDLE, START, DATA, STOP; bit_cnt 0..CLKS_PER_BIT-1; bit_idx 0..7; byte_idx 0..3.
//   IDLE : uart_tx=1. If level>0: pop head into shift reg word_q, byte_idx=0 -> START.
//   START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
//   DATA : uart_tx=current byte bit[bit_idx], LSB first, CLKS_PER_BIT cycles each; after bit 7 -> STOP.
//          current byte = word_q[31-8*byte_idx -: 8] (byte 0 = bits 31:24).
//   STOP : uart_tx=1 for CLKS_PER_BIT cycles; then if byte_idx<3: byte_idx++ -> START (no gap);
//          else -> IDLE (at least 1 idle-high cycle between words).
//  Latency: latch_in sampled at edge N with FIFO empty and FSM IDLE -> FIFO written at edge N,
//   popped at edge N+1, uart_tx low from edge N+2. One byte = 10*CLKS_PER_BIT cycles;
//   one word = 40*CLKS_PER_BIT cycles, plus 1 IDLE cycle before the next word.
//  uart_tx is driven from a flop (no combinational path from state decode) to avoid glitches.
//  busy = (level!=0) | (FSM!=IDLE); it is registered/derived from registers only.
//  Sustained throughput: pushes faster than one per 40*CLKS_PER_BIT+1 cycles eventually overflow;
//   the FIFO holds DEPTH words plus one in flight in the shifter.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Reset: hold rstn=0, toggle latch_in -> uart_tx=1, busy=0, level=0, overflow=0 throughout.
//  2 Push 0xA5C30F81 once -> uart_tx low 2 edges later; decode bytes A5,C3,0F,81 at 4 clk/bit,
//    160 cycles total; busy falls after the last stop bit; level returns to 0.
//  3 Push 6 words on consecutive cycles 0x00000001..0x00000006 -> first word in shifter, words 2..5
//    fill FIFO (level=4), word 6 dropped, overflow=1; serial stream carries words 1..5 only.
//  4 FIFO full, push on the exact cycle FSM pops (IDLE after word) -> word accepted, level stays 4,
//    overflow unchanged; verify order by decoding.
//  5 Assert rstn=0 mid-DATA of byte 2 -> uart_tx=1 immediately (async), FIFO empty; after release,
//    push 0x12345678 -> clean frame 12,34,56,78.
//  6 Back-to-back words 0xFFFFFFFF,0x00000000 -> exactly one idle-high cycle between the stop bit
//    of byte 3 and the next start bit; no gaps inside a word.

Source files
------------

// File: rtl/nanov_word_uart_tx.sv
// ---------------------------------------------------------------------------
// nanov_word_uart_tx
//   Buffers 32-bit CPU output words in a small FIFO and serialises each word
//   as four 8N1 UART bytes, MSB byte first and LSB bit first within a byte.
//   The CPU is never stalled. A word pushed while the FIFO is full (and no
//   pop happens in that cycle) is dropped, and the sticky overflow flag is set.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (>= 2)
//   FIFO_DEPTH   : FIFO word entries (power of 2, >= 2)
//
// Ports
//   clk        in   CPU clock, rising edge
//   rstn       in   asynchronous active-low reset
//   data_in    in   word to send, sampled when latch_in=1
//   latch_in   in   one-cycle push strobe
//   uart_tx    out  serial line, idle high, driven from a flop
//   busy       out  FIFO non-empty or frame in progress
//   overflow   out  sticky dropped-push flag, cleared only by reset
//   fifo_level out  words waiting in the FIFO (excludes the word in the shifter)
// ---------------------------------------------------------------------------
module nanov_word_uart_tx #(
    parameter int CLKS_PER_BIT = 347,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [31:0]                 data_in,
    input  logic                        latch_in,
    output logic                        uart_tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;

    // Serialiser
    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [1:0]       r_byte_idx;
    logic [31:0]      r_word;
    logic             r_tx;

    logic             w_pop;
    logic             w_push;
    logic             w_bit_last;
    logic [7:0]       w_cur_byte;

    // The FSM only pops from IDLE, so a full FIFO can still accept a push in
    // exactly that cycle because the head slot is freed at the same edge.
    assign w_pop      = (r_state == S_IDLE) && (r_level != '0);
    assign w_push     = latch_in && ((r_level != LVL_FULL) || w_pop);
    assign w_bit_last = (r_bit_cnt == CNT_LAST);

    // The shifter moves the next byte into [31:24] at every byte boundary,
    // so the byte on the wire is always the top byte of r_word.
    assign w_cur_byte = r_word[31:24];

    // NOTE: the storage array has no reset; a slot is only read after it was
    // written, because the level counter (which is reset) qualifies every pop.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the value from before this clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (latch_in && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Frame FSM. r_tx is computed from the current state, so the line lags
    // the state by one cycle uniformly and never sees a decode glitch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= w_cur_byte[r_bit_idx];
                default: r_tx <= 1'b1;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_word     <= r_mem[r_rd_ptr];
                        r_byte_idx <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_last) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_last) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_last) begin
                        r_bit_cnt <= '0;
                        if (r_byte_idx != 2'd3) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_word     <= {r_word[23:0], 8'h00};
                            r_state    <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign uart_tx    = r_tx;
    assign busy       = (r_level != '0) || (r_state != S_IDLE);
    assign overflow   = r_overflow;
    assign fifo_level = r_level;

endmodule
